branch_predict_unit: RTL

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution and 2-bit saturating-counter predictor with resolve/mispredict statistics.
// Decodes MIPS conditional branches, evaluates the condition, and trains a PC-indexed BHT.
module branch_predict_unit #(
    parameter int unsigned DW    = 32,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic             flush,
    input  logic [31:0]      res_pc,
    input  logic [5:0]       op,
    input  logic [4:0]       rt,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic             res_pred_taken,
    output logic             is_branch,
    output logic             res_taken,
    output logic             link,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    logic [ENTRIES-1:0][1:0] bht_q, bht_d;
    logic [CNT_W-1:0]        branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]        mispred_cnt_q, mispred_cnt_d;

    logic             is_branch_c, res_taken_c, link_c, resolve_c, mispredict_c;
    logic             a_neg, a_zero;
    logic [IDX_W-1:0] pred_idx, res_idx;
    logic [1:0]       res_entry;

    // PC bits outside the index field are intentionally ignored (aliasing, no tags).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], res_pc[31:IDX_W+2], res_pc[1:0]};

    assign pred_idx  = pred_pc[IDX_W+1:2];
    assign res_idx   = res_pc[IDX_W+1:2];
    assign a_neg     = a[DW-1];
    assign a_zero    = (a == '0);
    assign res_entry = bht_q[res_idx];

    // Branch decode and condition evaluation.
    always_comb begin
        is_branch_c = 1'b0;
        res_taken_c = 1'b0;
        link_c      = 1'b0;
        case (op)
            OP_BEQ:  begin is_branch_c = 1'b1; res_taken_c = (a == b);          end
            OP_BNE:  begin is_branch_c = 1'b1; res_taken_c = (a != b);          end
            OP_BLEZ: begin is_branch_c = 1'b1; res_taken_c = a_neg | a_zero;    end
            OP_BGTZ: begin is_branch_c = 1'b1; res_taken_c = ~a_neg & ~a_zero;  end
            OP_REGIMM: begin
                case (rt)
                    RT_BLTZ:   begin is_branch_c = 1'b1; res_taken_c = a_neg;  end
                    RT_BGEZ:   begin is_branch_c = 1'b1; res_taken_c = ~a_neg; end
                    RT_BLTZAL: begin is_branch_c = 1'b1; res_taken_c = a_neg;  link_c = 1'b1; end
                    RT_BGEZAL: begin is_branch_c = 1'b1; res_taken_c = ~a_neg; link_c = 1'b1; end
                    default:   ;
                endcase
            end
            default: ;
        endcase
    end

    assign resolve_c    = res_valid & ~flush & is_branch_c;
    assign mispredict_c = resolve_c & (res_taken_c != res_pred_taken);

    // Next-state for BHT training and saturating statistics.
    always_comb begin
        bht_d         = bht_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve_c) begin
            if (res_taken_c) begin
                if (res_entry != 2'b11) bht_d[res_idx] = res_entry + 2'd1;
            end else begin
                if (res_entry != 2'b00) bht_d[res_idx] = res_entry - 2'd1;
            end
            if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
            if (mispredict_c && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) bht_q[i] <= 2'b01;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            bht_q         <= bht_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pred_taken  = bht_q[pred_idx][1];
    assign is_branch   = is_branch_c;
    assign res_taken   = res_taken_c;
    assign link        = link_c;
    assign mispredict  = mispredict_c;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
